// File: rtl/instr_encoder_if.sv
// Request and instruction-memory signals of instr_encoder.
// The bench drives through master and the encoder uses slave.
interface instr_encoder_if;
  logic        Clear;
  logic        In_Valid;
  logic        In_Ready;
  logic [3:0]  Op;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [19:0] Imm;
  logic        Mem_WE;
  logic [7:0]  Mem_Addr;
  logic [31:0] Mem_WData;
  logic        Mem_Ack;
  logic [8:0]  Count;
  logic        Full;
  logic        Error;

  modport master (
    output Clear, In_Valid, Op, Rd, Rs1, Rs2, Imm, Mem_Ack,
    input  In_Ready, Mem_WE, Mem_Addr, Mem_WData, Count, Full, Error
  );

  modport slave (
    input  Clear, In_Valid, Op, Rd, Rs1, Rs2, Imm, Mem_Ack,
    output In_Ready, Mem_WE, Mem_Addr, Mem_WData, Count, Full, Error
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes (Op, fields) into RV32I words and writes them to sequential instruction-memory addresses.
// Define ENC_ILLEGAL_CHECK_EN to drop unsupported Ops and raise Error, instead of writing a NOP.
module instr_encoder (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, FULL} state_t;

  state_t      state;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [19:0] imm;
  logic [8:0]  count;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] word;

  always_comb begin
    word = 32'h0000_0013;
    case (op)
      4'd0: word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd1: word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd2: word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      4'd3: word = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      4'd4: word = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
      4'd5: word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      4'd6: word = {imm[19:0], rd, 7'b0110111};
      4'd7: word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      4'd8: word = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
      4'd9: word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      default: word = 32'h0000_0013;
    endcase
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  logic legal;
  logic err;
  assign legal     = (op <= 4'd9);
  assign bus.Error = err;
`else
  assign bus.Error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 9'd0;
      we    <= 1'b0;
      wdata <= 32'd0;
      op    <= 4'd0;
      rd    <= 5'd0;
      rs1   <= 5'd0;
      rs2   <= 5'd0;
      imm   <= 20'd0;
`ifdef ENC_ILLEGAL_CHECK_EN
      err   <= 1'b0;
`endif
    end else if (bus.Clear) begin
      // Clear wins over a pending accept or acknowledge on the same edge.
      state <= IDLE;
      count <= 9'd0;
      we    <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.In_Valid) begin
            op    <= bus.Op;
            rd    <= bus.Rd;
            rs1   <= bus.Rs1;
            rs2   <= bus.Rs2;
            imm   <= bus.Imm;
            state <= ENCODE;
          end
        end
        ENCODE: begin
`ifdef ENC_ILLEGAL_CHECK_EN
          if (!legal) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wdata <= word;
            we    <= 1'b1;
            state <= WRITE;
          end
`else
          wdata <= word;
          we    <= 1'b1;
          state <= WRITE;
`endif
        end
        WRITE: begin
          if (bus.Mem_Ack) begin
            we    <= 1'b0;
            count <= count + 9'd1;
            state <= (count == 9'd255) ? FULL : IDLE;
          end
        end
        FULL: begin
        end
      endcase
    end
  end

  assign bus.In_Ready  = (state == IDLE);
  assign bus.Full      = (state == FULL);
  assign bus.Mem_WE    = we;
  assign bus.Mem_WData = wdata;
  assign bus.Count     = count;
  assign bus.Mem_Addr  = count[7:0];

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: stimulus pushes expected {addr, word} into a queue,
// an independent monitor pops and compares on every rising edge of Mem_WE.
module tb_instr_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_count;
  logic [39:0] sb[$];

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: each new write strobe must match the oldest queued expectation.
  initial begin
    logic prev_we;
    logic [39:0] e;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Mem_WE === 1'b1 && prev_we !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h required=none", bus.Mem_WData);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", {24'd0, bus.Mem_Addr}, {24'd0, e[39:32]});
          chk("wr_data", bus.Mem_WData, e[31:0]);
        end
      end
      prev_we = bus.Mem_WE;
    end
  end

  task automatic drive_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [19:0] imm);
    bus.Op       = op;
    bus.Rd       = rd;
    bus.Rs1      = rs1;
    bus.Rs2      = rs2;
    bus.Imm      = imm;
    bus.In_Valid = 1'b1;
  endtask

  task automatic scramble();
    bus.In_Valid = 1'b0;
    bus.Op       = 4'($urandom);
    bus.Rd       = 5'($urandom);
    bus.Rs1      = 5'($urandom);
    bus.Rs2      = 5'($urandom);
    bus.Imm      = 20'($urandom);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.In_Ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.In_Ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=%b required=1", bus.In_Ready);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [19:0] imm,
                       input logic [31:0] word, input int ack_delay);
    wait_ready();
    sb.push_back({8'(exp_count), word});
    drive_req(op, rd, rs1, rs2, imm);
    @(negedge clk);
    scramble();
    chk("encode_we", {31'd0, bus.Mem_WE}, 32'd0);
    chk("encode_rdy", {31'd0, bus.In_Ready}, 32'd0);
    @(negedge clk);
    chk("write_we", {31'd0, bus.Mem_WE}, 32'd1);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      chk("hold_we", {31'd0, bus.Mem_WE}, 32'd1);
      chk("hold_data", bus.Mem_WData, word);
      chk("hold_addr", {24'd0, bus.Mem_Addr}, {24'd0, 8'(exp_count)});
      chk("hold_rdy", {31'd0, bus.In_Ready}, 32'd0);
    end
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    exp_count++;
    chk("count", {23'd0, bus.Count}, 32'(exp_count));
    chk("we_drop", {31'd0, bus.Mem_WE}, 32'd0);
  endtask

  task automatic do_clear();
    bus.Clear = 1'b1;
    @(negedge clk);
    bus.Clear = 1'b0;
    exp_count = 0;
    chk("clear_count", {23'd0, bus.Count}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_count = 0;
    rst_n       = 1'b0;
    bus.Clear   = 1'b0;
    bus.Mem_Ack = 1'b0;
    scramble();
    #3;
    chk("rst_ready", {31'd0, bus.In_Ready}, 32'd1);
    chk("rst_we", {31'd0, bus.Mem_WE}, 32'd0);
    chk("rst_count", {23'd0, bus.Count}, 32'd0);
    chk("rst_wdata", bus.Mem_WData, 32'd0);
    chk("rst_full", {31'd0, bus.Full}, 32'd0);
    chk("rst_error", {31'd0, bus.Error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd0, 5'd3, 5'd1, 5'd2, 20'd0, 32'h002081B3, 0);
    do_clear();
    issue(4'd1, 5'd5, 5'd6, 5'd7, 20'd0, 32'h407302B3, 0);
    issue(4'd6, 5'd1, 5'd9, 5'd9, 20'h12345, 32'h123450B7, 1);
    do_clear();
    issue(4'd5, 5'd31, 5'd1, 5'd2, 20'h00008, 32'h0020A423, 0);
    issue(4'd8, 5'd4, 5'd9, 5'd3, 20'h00FFF, 32'hFFF00213, 0);
    issue(4'd9, 5'd3, 5'd2, 5'd8, 20'h00004, 32'h00412183, 5);
    issue(4'd2, 5'd10, 5'd11, 5'd12, 20'd0, 32'h00C5F533, 0);
    issue(4'd3, 5'd1, 5'd2, 5'd3, 20'd0, 32'h003140B3, 2);
    issue(4'd4, 5'd31, 5'd31, 5'd31, 20'd0, 32'h01FF9FB3, 0);
    issue(4'd7, 5'd2, 5'd3, 5'd4, 20'hAB800, 32'h80018113, 0);

    // Acknowledge outside WRITE must not advance the pointer.
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    chk("stray_ack_count", {23'd0, bus.Count}, 32'(exp_count));

`ifdef ENC_ILLEGAL_CHECK_EN
    wait_ready();
    drive_req(4'd12, 5'd1, 5'd1, 5'd1, 20'd0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    chk("illegal_error", {31'd0, bus.Error}, 32'd1);
    chk("illegal_we", {31'd0, bus.Mem_WE}, 32'd0);
    chk("illegal_rdy", {31'd0, bus.In_Ready}, 32'd1);
    chk("illegal_count", {23'd0, bus.Count}, 32'(exp_count));
    do_clear();
    chk("clear_error", {31'd0, bus.Error}, 32'd0);
`else
    issue(4'd12, 5'd1, 5'd1, 5'd1, 20'hFFFFF, 32'h00000013, 0);
    chk("nop_error", {31'd0, bus.Error}, 32'd0);
`endif

    // Clear beats Mem_Ack while a write is pending.
    wait_ready();
    sb.push_back({8'(exp_count), 32'h002081B3});
    drive_req(4'd0, 5'd3, 5'd1, 5'd2, 20'd0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    bus.Clear   = 1'b1;
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    bus.Clear   = 1'b0;
    bus.Mem_Ack = 1'b0;
    exp_count   = 0;
    chk("clrwr_count", {23'd0, bus.Count}, 32'd0);
    chk("clrwr_we", {31'd0, bus.Mem_WE}, 32'd0);
    chk("clrwr_rdy", {31'd0, bus.In_Ready}, 32'd1);

    // Reset pulse mid-write aborts it without counting.
    issue(4'd0, 5'd3, 5'd1, 5'd2, 20'd0, 32'h002081B3, 0);
    sb.push_back({8'(exp_count), 32'h407302B3});
    drive_req(4'd1, 5'd5, 5'd6, 5'd7, 20'd0);
    @(negedge clk);
    scramble();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwr_we", {31'd0, bus.Mem_WE}, 32'd0);
    chk("rstwr_count", {23'd0, bus.Count}, 32'd0);
    chk("rstwr_rdy", {31'd0, bus.In_Ready}, 32'd1);
    #1 rst_n = 1'b1;
    exp_count = 0;
    @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      issue(4'd0, 5'd3, 5'd1, 5'd2, 20'd0, 32'h002081B3, 0);
    end
    chk("full_flag", {31'd0, bus.Full}, 32'd1);
    chk("full_rdy", {31'd0, bus.In_Ready}, 32'd0);
    bus.In_Valid = 1'b1;
    bus.Op       = 4'd1;
    bus.Mem_Ack  = 1'b1;
    repeat (3) @(negedge clk);
    bus.Mem_Ack  = 1'b0;
    chk("full_hold_count", {23'd0, bus.Count}, 32'd256);
    chk("full_hold_we", {31'd0, bus.Mem_WE}, 32'd0);
    chk("full_hold_flag", {31'd0, bus.Full}, 32'd1);
    bus.Clear = 1'b1;
    @(negedge clk);
    bus.Clear    = 1'b0;
    bus.In_Valid = 1'b0;
    exp_count    = 0;
    chk("fullclr_count", {23'd0, bus.Count}, 32'd0);
    chk("fullclr_rdy", {31'd0, bus.In_Ready}, 32'd1);
    chk("fullclr_full", {31'd0, bus.Full}, 32'd0);
    repeat (2) @(negedge clk);
    chk("noaccept_we", {31'd0, bus.Mem_WE}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
